// File: rtl/cmp_pkg.sv
// +------------------------------------------------------------------+
// | cmp_pkg: shared state and result encodings for the comparator    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

package cmp_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Result vectors are ordered {gt, eq, lt}
  localparam logic [2:0] RES_GT = 3'b100;
  localparam logic [2:0] RES_EQ = 3'b010;
  localparam logic [2:0] RES_LT = 3'b001;

endpackage

`default_nettype wire

// File: rtl/cmp_bit_cell.sv
// +------------------------------------------------------------------+
// | cmp_bit_cell: single-bit magnitude decision with sign-bit swap   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module cmp_bit_cell (
  input  logic a_bit,
  input  logic b_bit,
  input  logic invert,
  output logic bit_gt,
  output logic bit_lt
);

  logic a_hi;
  logic b_hi;

  assign a_hi = a_bit & ~b_bit;
  assign b_hi = ~a_bit & b_bit;

  // A set sign bit marks the smaller two's-complement value
  assign bit_gt = invert ? b_hi : a_hi;
  assign bit_lt = invert ? a_hi : b_hi;

endmodule

`default_nettype wire

// File: rtl/seq_magnitude_comparator.sv
// +------------------------------------------------------------------+
// | seq_magnitude_comparator: bit-serial MSB-first compare engine    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module seq_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic             sm;
  logic             first;
  logic             seen;
  logic             pend_gt;
  logic [CW-1:0]    cnt;
  logic             bit_gt;
  logic             bit_lt;
  logic             diff;
  logic             decide;
  logic [2:0]       res;

  cmp_bit_cell u_cell (
    .a_bit  (sa[WIDTH-1]),
    .b_bit  (sb[WIDTH-1]),
    .invert (sm & first),
    .bit_gt (bit_gt),
    .bit_lt (bit_lt)
  );

  assign diff   = bit_gt | bit_lt;
  assign decide = (EARLY_EXIT && diff) || (cnt == '0);

  // A difference latched earlier outranks the current bit pair
  always_comb begin
    res = RES_EQ;
    if (seen)        res = pend_gt ? RES_GT : RES_LT;
    else if (bit_gt) res = RES_GT;
    else if (bit_lt) res = RES_LT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      sa      <= '0;
      sb      <= '0;
      sm      <= 1'b0;
      first   <= 1'b0;
      seen    <= 1'b0;
      pend_gt <= 1'b0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      gt      <= 1'b0;
      eq      <= 1'b0;
      lt      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            sa      <= a;
            sb      <= b;
            sm      <= signed_mode;
            cnt     <= CNT_LAST;
            first   <= 1'b1;
            seen    <= 1'b0;
            pend_gt <= 1'b0;
            busy    <= 1'b1;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (decide) begin
            {gt, eq, lt} <= res;
            done         <= 1'b1;
            busy         <= 1'b0;
            state        <= ST_IDLE;
          end else begin
            sa    <= sa << 1;
            sb    <= sb << 1;
            cnt   <= cnt - 1'b1;
            first <= 1'b0;
            if (!seen && diff) begin
              seen    <= 1'b1;
              pend_gt <= bit_gt;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
